// File: rtl/elevator_controller_pkg.sv
// Shared types and default sizing for the single-car elevator sequencer.
package elevator_controller_pkg;

    localparam int NUM_FLOORS_DEF    = 8;
    localparam int FLOOR_W_DEF       = 3;
    localparam int TRAVEL_CYCLES_DEF = 4;
    localparam int DOOR_CYCLES_DEF   = 3;
    localparam int CNT_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;

endpackage

// File: rtl/elevator_controller_call_mask.sv
// Ahead/behind detection: any pending call strictly above or strictly below the car.
module ec_call_mask #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
) (
    input  logic [NUM_FLOORS-1:0] floors_called_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    output logic                  calls_above_o,
    output logic                  calls_below_o
);

    always_comb begin
        calls_above_o = 1'b0;
        calls_below_o = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floors_called_i[i]) begin
                if (i > int'(current_floor_i)) calls_above_o = 1'b1;
                if (i < int'(current_floor_i)) calls_below_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_controller.sv
// SCAN-policy sequencer: latches calls, steps the car one floor at a time, dwells at called floors.
module elevator_controller
    import elevator_controller_pkg::*;
#(
    parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
    parameter int FLOOR_W       = FLOOR_W_DEF,
    parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
    parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NUM_FLOORS-1:0] call_req_i,
    output logic [FLOOR_W-1:0]    current_floor_o,
    output logic [NUM_FLOORS-1:0] floors_called_o,
    output logic                  door_open_o,
    output logic                  moving_o,
    output logic                  going_up_o
);

    state_t                  state_q;
    logic [FLOOR_W-1:0]      current_floor_q;
    logic [NUM_FLOORS-1:0]   floors_called_q, floors_called_d;
    logic [NUM_FLOORS-1:0]   floor_onehot, clear_mask;
    logic                    going_up_q, door_open_q, moving_q;
    logic [CNT_W-1:0]        trav_cnt_q, door_cnt_q;
    logic                    calls_above, calls_below, at_call;

    ec_call_mask #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_mask (
        .floors_called_i (floors_called_q),
        .current_floor_i (current_floor_q),
        .calls_above_o   (calls_above),
        .calls_below_o   (calls_below)
    );

    assign at_call = floors_called_q[current_floor_q];

    // The current floor's bit is cleared when a stop is taken and kept clear for the
    // whole dwell, so a call for the open floor only extends the door time.
    always_comb begin
        floor_onehot                  = '0;
        floor_onehot[current_floor_q] = 1'b1;
        clear_mask                    = '0;
        if ((state_q == ST_IDLE && at_call) || state_q == ST_DOOR)
            clear_mask = floor_onehot;
        floors_called_d = (floors_called_q | call_req_i) & ~clear_mask;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            current_floor_q <= '0;
            floors_called_q <= '0;
            going_up_q      <= DIR_UP;
            door_open_q     <= 1'b0;
            moving_q        <= 1'b0;
            trav_cnt_q      <= '0;
            door_cnt_q      <= '0;
        end else begin
            floors_called_q <= floors_called_d;
            case (state_q)
                ST_IDLE: begin
                    if (at_call) begin
                        state_q     <= ST_DOOR;
                        door_cnt_q  <= CNT_W'(DOOR_CYCLES - 1);
                        door_open_q <= 1'b1;
                    end else if (going_up_q ? calls_above : calls_below) begin
                        state_q    <= ST_MOVE;
                        trav_cnt_q <= CNT_W'(TRAVEL_CYCLES - 1);
                        moving_q   <= 1'b1;
                    end else if (going_up_q ? calls_below : calls_above) begin
                        going_up_q <= ~going_up_q;
                        state_q    <= ST_MOVE;
                        trav_cnt_q <= CNT_W'(TRAVEL_CYCLES - 1);
                        moving_q   <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (trav_cnt_q == '0) begin
                        if (going_up_q) begin
                            if (current_floor_q != FLOOR_W'(NUM_FLOORS - 1))
                                current_floor_q <= current_floor_q + 1'b1;
                        end else if (current_floor_q != '0) begin
                            current_floor_q <= current_floor_q - 1'b1;
                        end
                        state_q  <= ST_IDLE;
                        moving_q <= 1'b0;
                    end else begin
                        trav_cnt_q <= trav_cnt_q - 1'b1;
                    end
                end
                ST_DOOR: begin
                    if (call_req_i[current_floor_q]) begin
                        door_cnt_q <= CNT_W'(DOOR_CYCLES - 1);
                    end else if (door_cnt_q == '0) begin
                        state_q     <= ST_IDLE;
                        door_open_q <= 1'b0;
                    end else begin
                        door_cnt_q <= door_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    door_open_q <= 1'b0;
                    moving_q    <= 1'b0;
                end
            endcase
        end
    end

    assign current_floor_o = current_floor_q;
    assign floors_called_o = floors_called_q;
    assign door_open_o     = door_open_q;
    assign moving_o        = moving_q;
    assign going_up_o      = going_up_q;

endmodule
